rx_cmd_sequencer: RTL and testbench

RX_CMD_SEQUENCER -- requirements
Module: rx_cmd_sequencer

---
 rtl/rx_cmd_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_rx_cmd_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_cmd_sequencer.sv
// rx_cmd_sequencer: decodes UART command frames into register-file accesses,
// ALU operations and TX FIFO responses.
module rx_cmd_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err,
    output logic [3:0]  reg_addr,
    output logic [7:0]  reg_wr_data,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    input  logic [7:0]  reg_rd_data,
    input  logic        reg_rd_valid,
    output logic [3:0]  alu_fun,
    output logic        alu_en,
    input  logic [15:0] alu_out,
    input  logic        alu_out_valid,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_full,
    output logic        alu_clk_en,
    output logic        busy
);

    localparam logic [7:0] CMD_WR  = 8'hAA;
    localparam logic [7:0] CMD_RD  = 8'hBB;
    localparam logic [7:0] CMD_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU = 8'hDD;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        OP_A     = 4'd5,
        OP_B     = 4'd6,
        ALU_FUN  = 4'd7,
        ALU_WAIT = 4'd8,
        SEND_LO  = 4'd9,
        SEND_HI  = 4'd10
    } state_t;

    state_t     state;
    logic [7:0] resp_hi;
    logic       two_byte;
    logic       rx_ok;
    logic       rx_bad;

    // Qualified byte strobes: only error-free bytes are consumed.
    assign rx_ok  = rx_valid & ~rx_err;
    assign rx_bad = rx_valid &  rx_err;

    // Command sequencer; busy and alu_clk_en are registered alongside each state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            alu_clk_en  <= 1'b0;
            reg_addr    <= 4'd0;
            reg_wr_data <= 8'd0;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            alu_fun     <= 4'd0;
            alu_en      <= 1'b0;
            tx_data     <= 8'd0;
            tx_wr       <= 1'b0;
            resp_hi     <= 8'd0;
            two_byte    <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            alu_en    <= 1'b0;
            tx_wr     <= 1'b0;

            if (rx_bad && (state inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN})) begin
                // A corrupted byte mid-frame drops the whole frame.
                state      <= IDLE;
                busy       <= 1'b0;
                alu_clk_en <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_ok) begin
                            case (rx_data)
                                CMD_WR: begin
                                    state <= WR_ADDR;
                                    busy  <= 1'b1;
                                end
                                CMD_RD: begin
                                    state <= RD_ADDR;
                                    busy  <= 1'b1;
                                end
                                CMD_OP: begin
                                    state      <= OP_A;
                                    busy       <= 1'b1;
                                    alu_clk_en <= 1'b1;
                                end
                                CMD_ALU: begin
                                    state      <= ALU_FUN;
                                    busy       <= 1'b1;
                                    alu_clk_en <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    WR_ADDR: begin
                        if (rx_ok) begin
                            reg_addr <= rx_data[3:0];
                            state    <= WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        if (rx_ok) begin
                            reg_wr_data <= rx_data;
                            reg_wr_en   <= 1'b1;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end
                    end
                    RD_ADDR: begin
                        if (rx_ok) begin
                            reg_addr  <= rx_data[3:0];
                            reg_rd_en <= 1'b1;
                            state     <= RD_WAIT;
                        end
                    end
                    RD_WAIT: begin
                        if (reg_rd_valid) begin
                            tx_data  <= reg_rd_data;
                            two_byte <= 1'b0;
                            state    <= SEND_LO;
                        end
                    end
                    OP_A: begin
                        if (rx_ok) begin
                            reg_addr    <= 4'd0;
                            reg_wr_data <= rx_data;
                            reg_wr_en   <= 1'b1;
                            state       <= OP_B;
                        end
                    end
                    OP_B: begin
                        if (rx_ok) begin
                            reg_addr    <= 4'd1;
                            reg_wr_data <= rx_data;
                            reg_wr_en   <= 1'b1;
                            state       <= ALU_FUN;
                        end
                    end
                    ALU_FUN: begin
                        if (rx_ok) begin
                            alu_fun <= rx_data[3:0];
                            alu_en  <= 1'b1;
                            state   <= ALU_WAIT;
                        end
                    end
                    ALU_WAIT: begin
                        if (alu_out_valid) begin
                            tx_data    <= alu_out[7:0];
                            resp_hi    <= alu_out[15:8];
                            two_byte   <= 1'b1;
                            state      <= SEND_LO;
                            alu_clk_en <= 1'b0;
                        end
                    end
                    SEND_LO: begin
                        // tx_data is already loaded and stays put while the FIFO is full.
                        if (!tx_full) begin
                            tx_wr <= 1'b1;
                            if (two_byte) begin
                                state <= SEND_HI;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    SEND_HI: begin
                        // Swap in the high byte only once the low-byte push has been presented.
                        if (tx_wr) begin
                            tx_data <= resp_hi;
                        end else if (!tx_full) begin
                            tx_wr <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        alu_clk_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// Testbench for rx_cmd_sequencer: directed frames plus randomized frames checked
// against a transaction-level model of expected strobe events.
module tb_rx_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_wr_data;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [7:0]  reg_rd_data = 8'd0;
    logic        reg_rd_valid = 1'b0;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic [15:0] alu_out = 16'd0;
    logic        alu_out_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_full = 1'b0;
    logic        alu_clk_en;
    logic        busy;

    // Event kinds recorded by the monitor
    localparam logic [7:0] EV_WR = 8'd1;
    localparam logic [7:0] EV_RD = 8'd2;
    localparam logic [7:0] EV_AL = 8'd3;
    localparam logic [7:0] EV_TX = 8'd4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];

    // Bench-controlled response and backpressure knobs
    logic [7:0]  rsp_rd    = 8'd0;
    logic [15:0] rsp_alu   = 16'd0;
    int          rsp_dly   = 2;
    logic        bp_en     = 1'b0;
    logic        hold_full = 1'b0;
    logic        prev_full = 1'b0;
    int          nstb;

    logic [7:0] cmd_tab [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    rx_cmd_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_err        (rx_err),
        .reg_addr      (reg_addr),
        .reg_wr_data   (reg_wr_data),
        .reg_wr_en     (reg_wr_en),
        .reg_rd_en     (reg_rd_en),
        .reg_rd_data   (reg_rd_data),
        .reg_rd_valid  (reg_rd_valid),
        .alu_fun       (alu_fun),
        .alu_en        (alu_en),
        .alu_out       (alu_out),
        .alu_out_valid (alu_out_valid),
        .tx_data       (tx_data),
        .tx_wr         (tx_wr),
        .tx_full       (tx_full),
        .alu_clk_en    (alu_clk_en),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record every strobe as an event; enforce one-hot strobes and no push while full.
    always @(negedge clk) begin
        if (rst_n) begin
            nstb = int'(reg_wr_en) + int'(reg_rd_en) + int'(alu_en) + int'(tx_wr);
            if (nstb != 0) check("strobe_onehot", 32'(nstb), 32'd1);
            if (reg_wr_en) obs_q.push_back({EV_WR, 4'd0, reg_addr, 8'd0, reg_wr_data});
            if (reg_rd_en) obs_q.push_back({EV_RD, 4'd0, reg_addr, 16'd0});
            if (alu_en) begin
                obs_q.push_back({EV_AL, 4'd0, alu_fun, 16'd0});
                check("alu_clk_en_run", 32'(alu_clk_en), 32'd1);
            end
            if (tx_wr) begin
                obs_q.push_back({EV_TX, 4'd0, 4'd0, 8'd0, tx_data});
                check("tx_wr_while_full", 32'(prev_full), 32'd0);
            end
        end
        prev_full = tx_full;
    end

    // Register file / ALU responder with configurable latency
    always begin
        @(negedge clk);
        if (reg_rd_en) begin
            repeat (rsp_dly) @(posedge clk);
            #1 reg_rd_data = rsp_rd; reg_rd_valid = 1'b1;
            @(posedge clk);
            #1 reg_rd_valid = 1'b0; reg_rd_data = 8'($urandom);
        end else if (alu_en) begin
            repeat (rsp_dly) @(posedge clk);
            #1 alu_out = rsp_alu; alu_out_valid = 1'b1;
            @(posedge clk);
            #1 alu_out_valid = 1'b0; alu_out = 16'($urandom);
        end
    end

    // TX FIFO full: random backpressure or a bench-held level
    always begin
        @(posedge clk);
        #1 tx_full = bp_en ? 1'($urandom_range(0, 1)) : hold_full;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic e, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_data = b; rx_valid = 1'b1; rx_err = e;
        @(posedge clk);
        #1 rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'($urandom);
    endtask

    task automatic expect_ev(input logic [7:0] k, input logic [3:0] a, input logic [15:0] d);
        exp_q.push_back({k, 4'd0, a, d});
    endtask

    // Wait for the frame to drain, then compare observed events with the model.
    task automatic finish_txn(input string tag);
        int budget;
        int n;
        budget = 0;
        while (busy && budget < 300) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_ev_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
        check({tag, "_alu_clk_en_idle"}, 32'(alu_clk_en), 32'd0);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] c, b1, b2, b3, j;
        int kind, p;
        logic junk;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_clk_en", 32'(alu_clk_en), 32'd0);
        check("rst_strobes", {28'd0, reg_wr_en, reg_rd_en, alu_en, tx_wr}, 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_reg_wr_data", 32'(reg_wr_data), 32'd0);
        check("rst_alu_fun", 32'(alu_fun), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Register write AA,05,3C
        send_byte(8'hAA, 1'b0, 0); send_byte(8'h05, 1'b0, 1); send_byte(8'h3C, 1'b0, 0);
        expect_ev(EV_WR, 4'h5, 16'h003C);
        finish_txn("wr");

        // Register read BB,07 -> 0x5A
        rsp_rd = 8'h5A; rsp_dly = 3;
        send_byte(8'hBB, 1'b0, 0); send_byte(8'h07, 1'b0, 0);
        expect_ev(EV_RD, 4'h7, 16'h0000); expect_ev(EV_TX, 4'h0, 16'h005A);
        finish_txn("rd");

        // Operand load and ALU op CC,12,34,00 -> 0x0046
        rsp_alu = 16'h0046; rsp_dly = 2;
        send_byte(8'hCC, 1'b0, 0); send_byte(8'h12, 1'b0, 0);
        check("op_alu_clk_en", 32'(alu_clk_en), 32'd1);
        send_byte(8'h34, 1'b0, 2); send_byte(8'h00, 1'b0, 0);
        expect_ev(EV_WR, 4'h0, 16'h0012); expect_ev(EV_WR, 4'h1, 16'h0034);
        expect_ev(EV_AL, 4'h0, 16'h0000);
        expect_ev(EV_TX, 4'h0, 16'h0046); expect_ev(EV_TX, 4'h0, 16'h0000);
        finish_txn("op");

        // FIFO full held for 10 cycles during the response
        hold_full = 1'b1; rsp_rd = 8'h5A; rsp_dly = 2;
        send_byte(8'hBB, 1'b0, 0); send_byte(8'h07, 1'b0, 0);
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            check("hold_tx_wr", 32'(tx_wr), 32'd0);
            check("hold_tx_data", 32'(tx_data), 32'h5A);
            check("hold_busy", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        hold_full = 1'b0;
        expect_ev(EV_RD, 4'h7, 16'h0000); expect_ev(EV_TX, 4'h0, 16'h005A);
        finish_txn("full");

        // Errored data byte aborts, next frame still works
        send_byte(8'hAA, 1'b0, 0); send_byte(8'h05, 1'b0, 0); send_byte(8'h3C, 1'b1, 0);
        check("abort_busy", 32'(busy), 32'd0);
        send_byte(8'hAA, 1'b0, 1); send_byte(8'h01, 1'b0, 0); send_byte(8'hFF, 1'b0, 0);
        expect_ev(EV_WR, 4'h1, 16'h00FF);
        finish_txn("abort");

        // Reset mid-frame, then an unknown command byte
        send_byte(8'hCC, 1'b0, 0); send_byte(8'h12, 1'b0, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_alu_clk_en", 32'(alu_clk_en), 32'd0);
        check("midrst_reg_wr_data", 32'(reg_wr_data), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send_byte(8'h77, 1'b0, 0);
        check("unknown_busy", 32'(busy), 32'd0);
        send_byte(8'h34, 1'b0, 2);
        expect_ev(EV_WR, 4'h0, 16'h0012);
        finish_txn("midrst");

        // Randomized frames
        for (int t = 0; t < 60; t++) begin
            kind    = $urandom_range(0, 5);
            bp_en   = 1'($urandom_range(0, 1));
            rsp_dly = $urandom_range(2, 5);
            rsp_rd  = 8'($urandom);
            rsp_alu = 16'($urandom);
            b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
            junk = 1'($urandom_range(0, 1));
            j = cmd_tab[$urandom_range(0, 3)];
            case (kind)
                0: begin
                    send_byte(8'hAA, 1'b0, $urandom_range(0, 2));
                    send_byte(b1, 1'b0, $urandom_range(0, 2));
                    send_byte(b2, 1'b0, $urandom_range(0, 2));
                    expect_ev(EV_WR, b1[3:0], {8'd0, b2});
                end
                1: begin
                    send_byte(8'hBB, 1'b0, $urandom_range(0, 2));
                    send_byte(b1, 1'b0, $urandom_range(0, 2));
                    if (junk) send_byte(j, 1'b0, 0);
                    expect_ev(EV_RD, b1[3:0], 16'd0);
                    expect_ev(EV_TX, 4'd0, {8'd0, rsp_rd});
                end
                2: begin
                    send_byte(8'hCC, 1'b0, $urandom_range(0, 2));
                    send_byte(b1, 1'b0, $urandom_range(0, 2));
                    send_byte(b2, 1'b0, $urandom_range(0, 2));
                    send_byte(b3, 1'b0, $urandom_range(0, 2));
                    if (junk) send_byte(j, 1'b0, 0);
                    expect_ev(EV_WR, 4'h0, {8'd0, b1});
                    expect_ev(EV_WR, 4'h1, {8'd0, b2});
                    expect_ev(EV_AL, b3[3:0], 16'd0);
                    expect_ev(EV_TX, 4'd0, {8'd0, rsp_alu[7:0]});
                    expect_ev(EV_TX, 4'd0, {8'd0, rsp_alu[15:8]});
                end
                3: begin
                    send_byte(8'hDD, 1'b0, $urandom_range(0, 2));
                    send_byte(b3, 1'b0, $urandom_range(0, 2));
                    if (junk) send_byte(j, 1'b0, 0);
                    expect_ev(EV_AL, b3[3:0], 16'd0);
                    expect_ev(EV_TX, 4'd0, {8'd0, rsp_alu[7:0]});
                    expect_ev(EV_TX, 4'd0, {8'd0, rsp_alu[15:8]});
                end
                4: begin
                    c = cmd_tab[$urandom_range(0, 3)];
                    p = (c == 8'hAA) ? $urandom_range(1, 2) : (c == 8'hCC) ? $urandom_range(1, 3) : 1;
                    send_byte(c, 1'b0, $urandom_range(0, 2));
                    if (p >= 2) send_byte(b1, 1'b0, $urandom_range(0, 2));
                    if (p >= 3) send_byte(b2, 1'b0, $urandom_range(0, 2));
                    send_byte(b3, 1'b1, $urandom_range(0, 2));
                    if (c == 8'hCC && p >= 2) expect_ev(EV_WR, 4'h0, {8'd0, b1});
                    if (c == 8'hCC && p >= 3) expect_ev(EV_WR, 4'h1, {8'd0, b2});
                end
                default: begin
                    while (b1 inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) b1 = 8'($urandom);
                    send_byte(b1, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
                    send_byte(j, 1'b1, 0);
                end
            endcase
            finish_txn($sformatf("rnd%0d", t));
            bp_en = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
